// File: rtl/zbt_wb_arbiter_if.sv
// Wishbone bus bundle between a master and the arbiter, or the arbiter and the ZBT slave.
// master drives the request side; slave returns read data and ack.
interface zbt_wb_arbiter_if #(
   parameter int unsigned AW = 19,
   parameter int unsigned DW = 16
);
   logic [AW:1]   adr;
   logic [DW-1:0] dat_w;
   logic [DW-1:0] dat_r;
   logic          we;
   logic [1:0]    sel;
   logic          stb;
   logic          cyc;
   logic          ack;

   modport master (output adr, dat_w, we, sel, stb, cyc, input dat_r, ack);
   modport slave  (input adr, dat_w, we, sel, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/zbt_wb_arbiter.sv
// Two-master Wishbone arbiter for the ZBT controller with a hung-slave timeout.
// Define ZBT_ARB_RR_EN for round-robin arbitration; otherwise master 1 has fixed priority.
module zbt_wb_arbiter #(
   parameter int unsigned AW    = 19,
   parameter int unsigned DW    = 16,
   parameter int unsigned TMO   = 255,
   parameter int unsigned TMO_W = 8
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   zbt_wb_arbiter_if.slave        m0_io,
   zbt_wb_arbiter_if.slave        m1_io,
   zbt_wb_arbiter_if.master       s_io,
   output logic [1:0]             gnt_o,
   output logic                   tmo_o
);

   typedef enum logic [1:0] {StIdle, StG0, StG1, StFlush} state_e;

   state_e             state_q, state_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
`ifdef ZBT_ARB_RR_EN
   logic               last_q, last_d;
`endif

   logic               req0, req1;
   logic               granted, sel1;
   logic               g_cyc, g_stb, g_we;
   logic [AW:1]        g_adr;
   logic [DW-1:0]      g_dat;
   logic [1:0]         g_sel;
   logic               fire;
   logic [DW-1:0]      mx_dat;

   // Granted-master view of the bus
   always_comb begin
      req0    = m0_io.cyc & m0_io.stb;
      req1    = m1_io.cyc & m1_io.stb;
      granted = (state_q == StG0) || (state_q == StG1);
      sel1    = (state_q == StG1);
      g_cyc   = sel1 ? m1_io.cyc   : m0_io.cyc;
      g_stb   = sel1 ? m1_io.stb   : m0_io.stb;
      g_we    = sel1 ? m1_io.we    : m0_io.we;
      g_adr   = sel1 ? m1_io.adr   : m0_io.adr;
      g_dat   = sel1 ? m1_io.dat_w : m0_io.dat_w;
      g_sel   = sel1 ? m1_io.sel   : m0_io.sel;
      fire    = granted & g_cyc & (tmo_cnt_q == TMO_W'(TMO));
   end

   always_comb begin
      s_io.adr   = '0;
      s_io.dat_w = '0;
      s_io.we    = 1'b0;
      s_io.sel   = 2'b00;
      s_io.stb   = 1'b0;
      s_io.cyc   = 1'b0;
      if (granted) begin
         s_io.adr   = g_adr;
         s_io.dat_w = g_dat;
         s_io.we    = g_we;
         s_io.sel   = g_sel;
         s_io.stb   = g_stb & g_cyc;
         s_io.cyc   = g_cyc;
      end
   end

   // A forced ack returns zero data so a hung read is distinguishable
   always_comb begin
      mx_dat      = fire ? '0 : s_io.dat_r;
      m0_io.dat_r = mx_dat;
      m1_io.dat_r = mx_dat;
      m0_io.ack   = (state_q == StG0) & g_cyc & (s_io.ack | fire);
      m1_io.ack   = (state_q == StG1) & g_cyc & (s_io.ack | fire);
      gnt_o       = {state_q == StG1, state_q == StG0};
      tmo_o       = fire;
   end

   always_comb begin
      state_d   = state_q;
      tmo_cnt_d = '0;
`ifdef ZBT_ARB_RR_EN
      last_d    = last_q;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef ZBT_ARB_RR_EN
            if (req0 && req1) begin
               state_d = last_q ? StG0 : StG1;
            end else if (req1) begin
               state_d = StG1;
            end else if (req0) begin
               state_d = StG0;
            end
            if (state_d == StG0) last_d = 1'b0;
            if (state_d == StG1) last_d = 1'b1;
`else
            if (req1) begin
               state_d = StG1;
            end else if (req0) begin
               state_d = StG0;
            end
`endif
         end
         StG0, StG1: begin
            if (!g_cyc) begin
               state_d = StIdle;
            end else if (fire) begin
               state_d = StFlush;
            end else if (!s_io.ack) begin
               tmo_cnt_d = g_stb ? tmo_cnt_q + TMO_W'(1) : tmo_cnt_q;
            end
         end
         StFlush: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q   <= StIdle;
         tmo_cnt_q <= '0;
`ifdef ZBT_ARB_RR_EN
         last_q    <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         tmo_cnt_q <= tmo_cnt_d;
`ifdef ZBT_ARB_RR_EN
         last_q    <= last_d;
`endif
      end
   end

endmodule
